// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave bit processor.
// Holds the FSM state encoding, the auxiliary-address defaults, the byte
// length and the address-match helper used by the top.
package i2c_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Auxiliary address window (SPI-bridge decode) defaults.
  localparam logic [6:0]  ALT_ADDR_BASE_DEF = 7'h40;
  localparam int unsigned ALT_ADDR_CNT_DEF  = 2;

  // Slave FSM state encoding.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR_DATA  = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD_DATA  = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  // True for the primary address or any address in [base, base+cnt).
  // Compared at 8 bits so base+cnt may run past 7'h7F without wrapping.
  function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] own,
                                      input logic [6:0] base, input logic [7:0] cnt);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = {1'b0, base};
    hi = lo + cnt;
    addr_match = (addr == own) || (({1'b0, addr} >= lo) && ({1'b0, addr} < hi));
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Input conditioner for one I2C line.
// 2-FF synchroniser followed by a run-length filter: the filtered value only
// follows the synchronised input after FILT_LEN consecutive differing samples.
// rise/fall are 1-clk pulses aligned with the cycle the filtered value changes.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   pin       - raw asynchronous line
//   filt      - filtered line level (resets to 1)
//   rise/fall - filtered edge pulses
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] LAST = 4'(FILT_LEN - 1);
  localparam logic [3:0] WARM = 4'(FILT_LEN);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;
  logic [3:0] warm;
  logic       warm_done;

  // Edge pulses stay suppressed until FILT_LEN samples have been seen.
  assign warm_done = (warm == WARM);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      filt  <= 1'b1;
      cnt   <= 4'd0;
      warm  <= 4'd0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (!warm_done) warm <= warm + 4'd1;
      if (sync2 != filt) begin
        if (cnt == LAST) begin
          filt <= sync2;
          cnt  <= 4'd0;
          rise <= sync2 & warm_done;
          fall <= ~sync2 & warm_done;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_bitproc.sv
// Bit-level I2C slave front end.
// Filters SCL/SDA, detects START/STOP, shifts address and data bytes, drives
// ACK and read data on SDA (open drain via sda_oe) and hands bytes to the
// packetiser. Pure slave: never stretches or drives SCL.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   scl_pin, sda_in - raw bus lines
//   sda_oe          - 1 pulls SDA low
//   reg_addr        - primary slave address
//   addr_r, rw      - address / R/W bit of the current or last transaction
//   addr_hit        - current transaction targets this block
//   byte_buf        - last received data byte, byte_done pulses when updated
//   tx_byte         - read data, sampled the clk after tx_req
//   tx_req, tx_nak  - read byte request / master NAK pulses
//   start_det, stop_det - bus condition pulses
module i2c_slave_bitproc
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_LEN      = 3,
  parameter logic [6:0]  ALT_ADDR_BASE = ALT_ADDR_BASE_DEF,
  parameter int unsigned ALT_ADDR_CNT  = ALT_ADDR_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_pin,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] reg_addr,
  output logic [6:0] addr_r,
  output logic       rw,
  output logic       addr_hit,
  output logic [7:0] byte_buf,
  output logic       byte_done,
  input  logic [7:0] tx_byte,
  output logic       tx_req,
  output logic       tx_nak,
  output logic       start_det,
  output logic       stop_det
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  logic       scl, scl_rise, scl_fall;
  logic       sda, sda_rise, sda_fall;
  logic       start, stop;
  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       full;     // byte complete (or read ACK seen), act on next fall
  logic       tx_load;  // tx_byte is valid this clk

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk  (clk),
    .rst  (rst),
    .pin  (scl_pin),
    .filt (scl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk  (clk),
    .rst  (rst),
    .pin  (sda_in),
    .filt (sda),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      full      <= 1'b0;
      tx_load   <= 1'b0;
      sda_oe    <= 1'b0;
      addr_r    <= 7'h00;
      rw        <= 1'b0;
      addr_hit  <= 1'b0;
      byte_buf  <= 8'h00;
      byte_done <= 1'b0;
      tx_req    <= 1'b0;
      tx_nak    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      tx_req    <= 1'b0;
      tx_nak    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      // Bus conditions win over any SCL edge in the same clk.
      if (start) begin
        start_det <= 1'b1;
        sda_oe    <= 1'b0;
        bit_cnt   <= 3'd0;
        full      <= 1'b0;
        tx_load   <= 1'b0;
        state     <= ST_ADDR;
      end else if (stop) begin
        stop_det  <= 1'b1;
        sda_oe    <= 1'b0;
        addr_hit  <= 1'b0;
        bit_cnt   <= 3'd0;
        full      <= 1'b0;
        tx_load   <= 1'b0;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                addr_r   <= shift[6:0];
                rw       <= sda;
                addr_hit <= addr_match(shift[6:0], reg_addr, ALT_ADDR_BASE,
                                       8'(ALT_ADDR_CNT));
                full     <= 1'b1;
              end
            end else if (scl_fall && full) begin
              full    <= 1'b0;
              bit_cnt <= 3'd0;
              if (addr_hit) begin
                sda_oe <= 1'b1;
                state  <= ST_ADDR_ACK;
              end else begin
                state  <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              if (rw) begin
                tx_req  <= 1'b1;
                tx_load <= 1'b1;
                state   <= ST_RD_DATA;
              end else begin
                state   <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                byte_buf  <= {shift[6:0], sda};
                byte_done <= 1'b1;
                full      <= 1'b1;
              end
            end else if (scl_fall && full) begin
              full   <= 1'b0;
              sda_oe <= 1'b1;
              state  <= ST_WR_ACK;
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (tx_load) begin
              tx_load <= 1'b0;
              shift   <= tx_byte;
              sda_oe  <= ~tx_byte[7];
            end else if (scl_fall) begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                sda_oe <= 1'b0;
                state  <= ST_RD_ACK;
              end else begin
                sda_oe <= ~shift[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda) begin
                tx_nak <= 1'b1;
                state  <= ST_IGNORE;
              end else begin
                full   <= 1'b1;
              end
            end else if (scl_fall && full) begin
              full    <= 1'b0;
              bit_cnt <= 3'd0;
              tx_req  <= 1'b1;
              tx_load <= 1'b1;
              state   <= ST_RD_DATA;
            end
          end
          ST_IGNORE: sda_oe <= 1'b0;
          default:   state  <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_bitproc.sv
// Self-checking bench for i2c_slave_bitproc: a bit-banged I2C master with an
// open-drain SDA model, a byte scoreboard fed when write bytes are driven and
// drained on byte_done, and event counters for the pulse outputs.
module tb_i2c_slave_bitproc;
  import i2c_pkg::*;

  localparam int Q = 10;  // quarter SCL period in clks

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       sda_line;
  logic       sda_oe;
  logic [6:0] reg_addr, addr_r;
  logic       rw, addr_hit, byte_done, tx_req, tx_nak, start_det, stop_det;
  logic [7:0] byte_buf, tx_byte;

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_bitproc dut (
    .clk       (clk),
    .rst       (rst),
    .scl_pin   (m_scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .addr_r    (addr_r),
    .rw        (rw),
    .addr_hit  (addr_hit),
    .byte_buf  (byte_buf),
    .byte_done (byte_done),
    .tx_byte   (tx_byte),
    .tx_req    (tx_req),
    .tx_nak    (tx_nak),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  int c_done = 0, c_start = 0, c_stop = 0, c_req = 0, c_nak = 0;
  logic oe_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sample outputs away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_done) begin
        logic [7:0] e;
        c_done++;
        check_eq("byte_done expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("byte_buf", 32'(byte_buf), 32'(e));
        end
      end
      if (tx_req) begin
        c_req++;
        tx_byte = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
      end
      if (tx_nak)    c_nak++;
      if (start_det) c_start++;
      if (stop_det)  c_stop++;
      if (sda_oe)    oe_seen = 1'b1;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_n(Q);
    m_scl = 1'b1; wait_n(2*Q);
    m_sda = 1'b0; wait_n(2*Q);
    m_scl = 1'b0; wait_n(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_n(Q);
    m_scl = 1'b1; wait_n(2*Q);
    m_sda = 1'b1; wait_n(2*Q);
  endtask

  task automatic clock_bit(input logic b, output logic sda_s, output logic oe_s);
    m_sda = b;    wait_n(Q);
    m_scl = 1'b1; wait_n(Q);
    sda_s = sda_line;
    oe_s  = sda_oe;
    wait_n(Q);
    m_scl = 1'b0; wait_n(Q);
  endtask

  // Master write of one byte plus the ACK slot; optional short SCL glitch
  // after bit index glitch_at (counting from the MSB, 7 down to 0).
  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input logic push,
                            input int glitch_at, input string tag);
    logic s, oe;
    if (push) exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], s, oe);
      if (i == glitch_at) begin
        m_scl = 1'b1; wait_n(2);
        m_scl = 1'b0; wait_n(Q);
      end
    end
    clock_bit(1'b1, s, oe);
    check_eq({tag, " ack"}, 32'(oe), 32'(exp_ack));
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nak, input string tag);
    logic s, oe, e;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s, oe);
      e = ~exp[i];
      check_eq($sformatf("%s oe bit%0d", tag, i), 32'(oe), 32'(e));
    end
    clock_bit(nak, s, oe);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int s_done, s_start, s_stop, s_req, s_nak;
    logic s, oe;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; reg_addr = 7'h2A; tx_byte = 8'h00;
    wait_n(3);
    check_eq("reset ctrl", 32'({sda_oe, byte_done, tx_req, tx_nak, start_det, stop_det,
                                addr_hit, rw}), 32'd0);
    check_eq("reset data", 32'({addr_r, byte_buf}), 32'd0);
    check_eq("reset state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    wait_n(20);

    // Write 2A: A5, 3C, STOP.
    s_done = c_done; s_stop = c_stop;
    i2c_start();
    write_byte({7'h2A, 1'b0}, 1'b1, 1'b0, -1, "wr addr");
    check_eq("wr addr_hit", 32'(addr_hit), 32'd1);
    check_eq("wr addr_r", 32'(addr_r), 32'h2A);
    check_eq("wr rw", 32'(rw), 32'd0);
    write_byte(8'hA5, 1'b1, 1'b1, -1, "wr A5");
    write_byte(8'h3C, 1'b1, 1'b1, -1, "wr 3C");
    i2c_stop();
    wait_n(Q);
    check_eq("wr byte_done count", 32'(c_done - s_done), 32'd2);
    check_eq("wr stop count", 32'(c_stop - s_stop), 32'd1);
    check_eq("wr hit after stop", 32'(addr_hit), 32'd0);
    check_eq("wr addr_r held", 32'(addr_r), 32'h2A);

    // Address miss.
    s_done = c_done; oe_seen = 1'b0;
    i2c_start();
    write_byte({7'h15, 1'b0}, 1'b0, 1'b0, -1, "miss addr");
    check_eq("miss addr_hit", 32'(addr_hit), 32'd0);
    write_byte(8'h11, 1'b0, 1'b0, -1, "miss d0");
    write_byte(8'h22, 1'b0, 1'b0, -1, "miss d1");
    i2c_stop();
    wait_n(Q);
    check_eq("miss oe never", 32'(oe_seen), 32'd0);
    check_eq("miss byte_done", 32'(c_done - s_done), 32'd0);
    check_eq("miss addr_r", 32'(addr_r), 32'h15);

    // Read 2A: C3 (ACK), 81 (NAK).
    s_req = c_req; s_nak = c_nak;
    tx_q.push_back(8'hC3); tx_q.push_back(8'h81);
    i2c_start();
    write_byte({7'h2A, 1'b1}, 1'b1, 1'b0, -1, "rd addr");
    check_eq("rd rw", 32'(rw), 32'd1);
    read_byte(8'hC3, 1'b0, "rd C3");
    read_byte(8'h81, 1'b1, "rd 81");
    check_eq("rd state ignore", 32'(dut.state), 32'(ST_IGNORE));
    check_eq("rd tx_req count", 32'(c_req - s_req), 32'd2);
    check_eq("rd tx_nak count", 32'(c_nak - s_nak), 32'd1);
    i2c_stop();
    wait_n(Q);

    // Auxiliary address window: 40 hits, 42 misses.
    i2c_start();
    write_byte({7'h40, 1'b0}, 1'b1, 1'b0, -1, "alt40 addr");
    check_eq("alt40 addr_hit", 32'(addr_hit), 32'd1);
    check_eq("alt40 addr_r", 32'(addr_r), 32'h40);
    write_byte(8'h02, 1'b1, 1'b1, -1, "alt40 02");
    i2c_stop();
    i2c_start();
    write_byte({7'h42, 1'b0}, 1'b0, 1'b0, -1, "alt42 addr");
    check_eq("alt42 addr_hit", 32'(addr_hit), 32'd0);
    i2c_stop();
    wait_n(Q);

    // Repeated START after 4 data bits, then read.
    s_done = c_done; s_start = c_start;
    i2c_start();
    write_byte({7'h2A, 1'b0}, 1'b1, 1'b0, -1, "rs addr");
    for (int i = 0; i < 4; i++) clock_bit(i[0], s, oe);
    tx_q.push_back(8'h5A);
    i2c_start();
    write_byte({7'h2A, 1'b1}, 1'b1, 1'b0, -1, "rs rd addr");
    read_byte(8'h5A, 1'b1, "rs rd 5A");
    i2c_stop();
    wait_n(Q);
    check_eq("rs byte_done", 32'(c_done - s_done), 32'd0);
    check_eq("rs start count", 32'(c_start - s_start), 32'd2);

    // Short SCL glitch mid-byte must not add a bit.
    s_done = c_done;
    i2c_start();
    write_byte({7'h2A, 1'b0}, 1'b1, 1'b0, -1, "gl addr");
    write_byte(8'h96, 1'b1, 1'b1, 4, "gl 96");
    i2c_stop();
    wait_n(Q);
    check_eq("gl byte_done", 32'(c_done - s_done), 32'd1);

    // Reset mid-transaction while the slave holds ACK.
    i2c_start();
    write_byte({7'h2A, 1'b0}, 1'b1, 1'b0, -1, "rst addr");
    exp_q.push_back(8'h77);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'h77;
      clock_bit(v[i], s, oe);
    end
    check_eq("rst ack held", 32'(sda_oe), 32'd1);
    s_start = c_start; s_stop = c_stop;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wait_n(1);
    check_eq("rst ctrl", 32'({sda_oe, byte_done, tx_req, tx_nak, start_det, stop_det,
                              addr_hit, rw}), 32'd0);
    check_eq("rst addr_r", 32'(addr_r), 32'd0);
    check_eq("rst byte_buf", 32'(byte_buf), 32'd0);
    check_eq("rst state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    wait_n(4*Q);
    check_eq("post-rst no edges", 32'((c_start - s_start) + (c_stop - s_stop)), 32'd0);
    check_eq("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_bitproc.md
Name: i2c_slave_bitproc

Overview:
- Bit-level I2C slave front end. Sits directly upstream of the Wishbone I2C wrapper's packet logic and feeds its byte stream.
- Synchronises and deglitches SCL/SDA, detects START/STOP, and shifts the address and data bytes.
- Drives ACK and read data on SDA.
- Presents byte_buf/byte_done/addr_r for the packetiser and the SPI-bridge decode (addresses 7'h40/7'h41).

Parameters:
FILT_LEN, 3, consecutive identical samples needed before the filtered line changes (range 1..15)
ALT_ADDR_BASE, 7'h40, first auxiliary slave address that is always ACKed
ALT_ADDR_CNT, 2, number of consecutive auxiliary addresses ACKed

Ports:
clk  in  1  system clock; the block has one clock
rst  in  1  synchronous, active-high reset
scl_pin  in  1  raw SCL, asynchronous to clk
sda_in  in  1  raw SDA pad input
sda_oe  out  1  1 = pull SDA low; 0 = release
reg_addr  in  7  primary slave address
addr_r  out  7  address of the current or last transaction
rw  out  1  R/W bit of the current transaction (1 = read)
addr_hit  out  1  level; the current transaction is addressed to this block
byte_buf  out  8  last received data byte
byte_done  out  1  1-clk pulse; byte_buf is newly valid
tx_byte  in  8  next read byte; sampled on the clk after tx_req
tx_req  out  1  1-clk pulse requesting the next read byte
tx_nak  out  1  1-clk pulse; master NAKed a read byte
start_det  out  1  1-clk pulse on START or repeated START
stop_det  out  1  1-clk pulse on STOP

Behaviour:
- Reset values: state IDLE; sda_oe, byte_done, tx_req, tx_nak, start_det, stop_det, addr_hit, rw = 0; addr_r, byte_buf = 0.
- Filters come up at 1 with history cleared. No edges are reported until FILT_LEN samples have been taken after reset.
- Input path per line: 2-FF synchroniser, then a filter.
  - The filter output takes the new value only after FILT_LEN consecutive equal samples.
  - Edge pulses come from the filtered value. Pin-to-edge latency is 2+FILT_LEN clks.
- START = filtered SDA falls while filtered SCL is high. STOP = filtered SDA rises while SCL is high.
- Data is sampled on SCL rise. sda_oe changes only in the clk after an SCL fall.
- A 3-bit counter counts bits within a byte; 8 bits per byte, then the ACK slot.
- States:
  - IDLE: wait for START.
  - ADDR: shift 7 address bits plus R/W on 8 rises.
    - After the 8th rise: latch addr_r and rw.
    - addr_hit = (addr == reg_addr) or (ALT_ADDR_BASE <= addr < ALT_ADDR_BASE+ALT_ADDR_CNT).
    - Hit: at the next SCL fall go to ADDR_ACK with sda_oe=1. Miss: go to IGNORE with sda_oe=0.
  - ADDR_ACK: at the next SCL fall, release sda_oe.
    - rw=0: go to WR_DATA.
    - rw=1: pulse tx_req and go to RD_DATA.
  - WR_DATA: shift 8 bits.
    - After the 8th rise: byte_buf <= shift and pulse byte_done for 1 clk.
    - At the next fall: sda_oe=1 and go to WR_ACK.
  - WR_ACK: at the next fall, release sda_oe and go to WR_DATA.
  - RD_DATA:
    - On the clk after tx_req, load tx_byte into the shift register and drive sda_oe = ~shift[7].
    - At each SCL fall, shift left and update sda_oe. After the 8th fall, release and go to RD_ACK.
  - RD_ACK: sample SDA at the SCL rise.
    - 0 (ACK): at the next fall pulse tx_req and go to RD_DATA.
    - 1 (NAK): pulse tx_nak and go to IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- START in any state:
  - pulse start_det, release sda_oe, clear the bit counter, go to ADDR;
  - a partial byte is discarded with no byte_done.
- STOP in any state:
  - pulse stop_det, release sda_oe, clear addr_hit, go to IDLE;
  - a partial byte is discarded.
- addr_r and byte_buf hold their values through IDLE.
- START/STOP take priority over any SCL edge seen in the same clk.
- The block is a pure slave: no clock stretching; SCL is never driven.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - the ALT_ADDR_BASE/ALT_ADDR_CNT defaults;
  - the localparam BITS_PER_BYTE=8.
- One sub-module, i2c_line_filter (synchroniser + FILT_LEN filter + rise/fall pulses), instantiated for SCL and for SDA.

Test Plan:
- Write to reg_addr=7'h2A with bytes 8'hA5, 8'h3C, then STOP:
  - ACK driven on the 9th clock of each byte;
  - byte_done pulses twice with byte_buf 8'hA5 then 8'h3C;
  - stop_det pulses once.
- Address 7'h15 while reg_addr=7'h2A, then 2 bytes: sda_oe never asserts, no byte_done, addr_hit=0.
- Read from 7'h2A, tx_byte 8'hC3 then 8'h81, master ACKs then NAKs:
  - sda_oe pattern equals ~bits of the bytes;
  - tx_req pulses twice, tx_nak pulses once, then IGNORE.
- Write to 7'h40 with byte 8'h02: addr_hit=1, ACKed, addr_r=7'h40, byte_done with byte_buf=8'h02.
- Repeated START after 4 bits of a data byte, then address 7'h2A read: no byte_done, start_det pulses, read proceeds.
- SCL glitch shorter than FILT_LEN clks mid-byte: no extra bit is shifted and the received byte is unchanged. Also assert rst mid-transaction: all outputs return to reset values the next clk.
